// File: rtl/pwm_rx.sv
// pwm_rx: recovers the duty level of a 2^WIDTH-clock PWM stream and flags bad periods.
// Optional glitch filter on the synchronized input: define PWM_RX_GLITCH_FILTER_EN.
module pwm_rx #(
  parameter int unsigned WIDTH  = 6,
  parameter bit          INVERT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] level,
  output logic             valid,
  output logic             period_err,
  output logic             locked
);

  localparam int unsigned PW = WIDTH + 2;
  localparam int unsigned HW = WIDTH + 1;

  localparam logic [PW-1:0] P_ONE = PW'(1);
  localparam logic [HW-1:0] H_ONE = HW'(1);
  localparam logic [PW-1:0] P_NOM = P_ONE << WIDTH;
  localparam logic [PW-1:0] P_TMO = P_ONE << (WIDTH + 1);
  localparam logic [PW-1:0] P_MAX = '1;
  localparam logic [HW-1:0] H_MAX = '1;

  typedef enum logic [1:0] {
    SEEK  = 2'd0,
    TRACK = 2'd1,
    STUCK = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [1:0]       sync_q;
  logic             synced;
  logic             s_q, s_d;
  logic             s_prev_q;
  logic             rise;
  logic             tmo;

  logic [PW-1:0]    p_cnt_q, p_cnt_d;
  logic [HW-1:0]    h_cnt_q, h_cnt_d;

  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] meas_lvl;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             locked_q, locked_d;

  assign synced = sync_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], pwm_in};
    end
  end

`ifdef PWM_RX_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  logic       stable;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= '0;
    end else begin
      hist_q <= {hist_q[0], synced};
    end
  end

  // Follow the input only once three consecutive samples agree.
  assign stable = (synced == hist_q[0]) && (synced == hist_q[1]);
  assign s_d    = stable ? (synced ^ INVERT) : s_q;
`else
  assign s_d = synced ^ INVERT;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q      <= 1'b0;
      s_prev_q <= 1'b0;
    end else begin
      s_q      <= s_d;
      s_prev_q <= s_q;
    end
  end

  assign rise = s_q & ~s_prev_q;
  assign tmo  = (p_cnt_q == P_TMO);

  // The rise cycle itself is the first clock of the new period.
  always_comb begin
    p_cnt_d = p_cnt_q;
    h_cnt_d = h_cnt_q;
    if (rise) begin
      p_cnt_d = P_ONE;
      h_cnt_d = H_ONE;
    end else begin
      if (p_cnt_q != P_MAX) begin
        p_cnt_d = p_cnt_q + P_ONE;
      end
      if (s_q && (h_cnt_q != H_MAX)) begin
        h_cnt_d = h_cnt_q + H_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_cnt_q <= '0;
      h_cnt_q <= '0;
    end else begin
      p_cnt_q <= p_cnt_d;
      h_cnt_q <= h_cnt_d;
    end
  end

  // High time can only reach 2^WIDTH without a falling edge; clamp to full scale.
  assign meas_lvl = h_cnt_q[WIDTH] ? '1 : h_cnt_q[WIDTH-1:0];

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    locked_d = locked_q;
    unique case (state_q)
      SEEK: begin
        if (rise) begin
          state_d = TRACK;
        end else if (tmo) begin
          level_d  = s_q ? '1 : '0;
          valid_d  = 1'b1;
          locked_d = 1'b0;
          state_d  = STUCK;
        end
      end
      TRACK: begin
        if (rise) begin
          if (p_cnt_q == P_NOM) begin
            level_d  = meas_lvl;
            valid_d  = 1'b1;
            locked_d = 1'b1;
          end else begin
            err_d    = 1'b1;
            locked_d = 1'b0;
          end
        end else if (tmo) begin
          level_d  = s_q ? '1 : '0;
          valid_d  = 1'b1;
          locked_d = 1'b0;
          state_d  = STUCK;
        end
      end
      STUCK: begin
        if (rise) begin
          state_d = TRACK;
        end
      end
      default: begin
        state_d = SEEK;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= SEEK;
      level_q  <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      locked_q <= locked_d;
    end
  end

  assign level      = level_q;
  assign valid      = valid_q;
  assign period_err = err_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_pwm_rx.sv
// tb_pwm_rx: period-level reference model feeding a scoreboard of expected
// valid/period_err pulses; a second INVERT=1 instance sees a constant-low input.
module tb_pwm_rx;

  localparam int W    = 6;
  localparam int NOM  = 1 << W;
  localparam int TMO  = 1 << (W + 1);
  localparam int FULL = NOM - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         pwm_in;
  logic         pwm_inv;
  logic [W-1:0] level, level_inv;
  logic         valid, period_err, locked;
  logic         valid_inv, err_inv, locked_inv;

  always #5 clk = ~clk;

  pwm_rx #(.WIDTH(W), .INVERT(1'b0)) dut (
    .clk(clk), .reset(reset), .pwm_in(pwm_in),
    .level(level), .valid(valid),
    .period_err(period_err), .locked(locked)
  );

  pwm_rx #(.WIDTH(W), .INVERT(1'b1)) dut_inv (
    .clk(clk), .reset(reset), .pwm_in(pwm_inv),
    .level(level_inv), .valid(valid_inv),
    .period_err(err_inv), .locked(locked_inv)
  );

  typedef struct packed {
    bit is_err;
    int lvl;
    bit lck;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  errors = 0;

  // Reference model: 0 = hunting, 1 = measuring, 2 = parked after timeout
  int  m_mode;
  int  m_prev_p;
  int  m_prev_h;
  int  m_lvl;
  bit  m_lck;

  int  inv_cnt = 0;
  int  inv_err_cnt = 0;
  int  inv_lvl = 0;

  function automatic void push(bit e, int l, bit k);
    ev_t x;
    x.is_err = e;
    x.lvl    = l;
    x.lck    = k;
    q.push_back(x);
  endfunction

  // A rising edge closes the previous period if one was being measured.
  function automatic void model_rise();
    if (m_mode == 1) begin
      if (m_prev_p == NOM) begin
        m_lvl = m_prev_h;
        m_lck = 1'b1;
        push(1'b0, m_lvl, 1'b1);
      end else begin
        m_lck = 1'b0;
        push(1'b1, m_lvl, 1'b0);
      end
    end
    m_mode = 1;
  endfunction

  function automatic void model_period(int h, int p);
    model_rise();
    m_prev_p = p;
    m_prev_h = h;
    if (p > TMO) begin
      m_lvl  = (h > TMO) ? FULL : 0;
      m_lck  = 1'b0;
      m_mode = 2;
      push(1'b0, m_lvl, 1'b0);
    end
  endfunction

  task automatic hold(bit v, int n);
    pwm_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic period(int h, int p);
    model_period(h, p);
    hold(1'b1, h);
    hold(1'b0, p - h);
  endtask

  // 64-clock period with a single-clock spike in its low phase.
  task automatic glitch_period();
`ifdef PWM_RX_GLITCH_FILTER_EN
    model_period(20, 64);
`else
    model_period(20, 30);
    model_period(1, 34);
`endif
    hold(1'b1, 20);
    hold(1'b0, 10);
    hold(1'b1, 1);
    hold(1'b0, 33);
  endtask

  task automatic check_zero(string name);
    checks++;
    if (level !== '0 || valid !== 1'b0 || period_err !== 1'b0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL %s level=%0d valid=%0b period_err=%0b locked=%0b required all 0",
               name, level, valid, period_err, locked);
    end
  endtask

  task automatic drain(string name);
    for (int i = 0; i < 400 && q.size() != 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s pending=%0d required 0", name, q.size());
      q.delete();
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (!reset && (valid || period_err)) begin
      checks++;
      if (valid && period_err) begin
        errors++;
        $display("FAIL both_pulses valid=1 period_err=1 required exclusive");
      end else if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse valid=%0b period_err=%0b level=%0d",
                 valid, period_err, level);
      end else begin
        e = q.pop_front();
        if (period_err != e.is_err || int'(level) != e.lvl || locked != e.lck) begin
          errors++;
          $display("FAIL pulse got err=%0b level=%0d locked=%0b required err=%0b level=%0d locked=%0b",
                   period_err, level, locked, e.is_err, e.lvl, e.lck);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && valid_inv) begin
      inv_cnt++;
      inv_lvl = int'(level_inv);
    end
    if (!reset && err_inv) inv_err_cnt++;
  end

  initial begin
    int h;
    int p;
    int r;
    reset    = 1'b1;
    pwm_in   = 1'b0;
    pwm_inv  = 1'b0;
    m_mode   = 0;
    m_prev_p = 0;
    m_prev_h = 0;
    m_lvl    = 0;
    m_lck    = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    reset = 1'b0;
    @(negedge clk);

    repeat (6) period(20, 64);
    repeat (3) period(45, 64);
    period(20, 220);
    repeat (4) period(20, 60);
    repeat (3) period(20, 64);
    glitch_period();
    repeat (2) period(20, 64);

    for (int i = 0; i < 30; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6) p = NOM;
      else if (r < 9) p = int'($urandom_range(40, 100));
      else p = int'($urandom_range(130, 200));
      h = int'($urandom_range(3, p - 3));
      period(h, p);
    end

    model_rise();
    hold(1'b1, 10);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pre_reset_drain pending=%0d required 0", q.size());
      q.delete();
    end
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    pwm_in = 1'b0;
    m_mode = 0;
    m_lvl  = 0;
    m_lck  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) period(20, 64);
    period(33, 300);
    drain("final_drain");

    checks++;
    if (inv_cnt != 2 || inv_lvl != FULL || inv_err_cnt != 0 || locked_inv !== 1'b0) begin
      errors++;
      $display("FAIL invert_stuck count=%0d level=%0d errs=%0d locked=%0b required 2 %0d 0 0",
               inv_cnt, inv_lvl, inv_err_cnt, locked_inv, FULL);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
